// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU control path: sequencer states, next-PC ops,
// trap causes and the canonical NOP.
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_HALT  = 3'd3,
      ST_TRAP  = 3'd4
   } state_t;

   localparam logic [1:0] NPC_SEQ  = 2'b00;
   localparam logic [1:0] NPC_JALR = 2'b01;
   localparam logic [1:0] NPC_BR   = 2'b10;
   localparam logic [1:0] NPC_JAL  = 2'b11;

   localparam logic [1:0] TRAP_NONE     = 2'b00;
   localparam logic [1:0] TRAP_MISALIGN = 2'b01;
   localparam logic [1:0] TRAP_TIMEOUT  = 2'b10;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/pc_sequencer.sv
// Fetch/commit sequencer: owns the PC, runs FETCH->EXEC against an acked imem,
// gates decoder next-PC controls, traps misaligned targets and fetch timeouts.
module pc_sequencer
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int unsigned FETCH_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic        inst_valid,
   input  logic [1:0]  dec_npc_op,
   input  logic        dec_br_taken,
   output logic [1:0]  npc_op,
   output logic        npc_if_branch,
   output logic [31:0] pc,
   input  logic [31:0] npc,
   input  logic        exec_stall,
   input  logic        halt,
   output logic        halted,
   output logic        trap,
   output logic [1:0]  trap_cause,
   output logic [31:0] trap_pc,
   output logic [31:0] instret
);

   // A disabled timeout still needs a 1-bit counter to keep the code legal.
   localparam int CW = (FETCH_TIMEOUT > 0) ? $clog2(FETCH_TIMEOUT + 1) : 1;

   state_t          state_q, state_d;
   logic [31:0]     pc_q, inst_q, instret_q, trap_pc_q;
   logic [1:0]      trap_cause_q;
   logic [CW-1:0]   tmo_cnt;
   logic            timeout_hit;
   logic            misaligned;

   assign timeout_hit = (FETCH_TIMEOUT != 0) && ((32'(tmo_cnt) + 32'd1) == FETCH_TIMEOUT);
   assign misaligned  = (npc[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: begin
            if (imem_ack)         state_d = ST_EXEC;
            else if (timeout_hit) state_d = ST_TRAP;
         end
         ST_EXEC: begin
            if (!exec_stall) begin
               if (misaligned) state_d = ST_TRAP;
               else if (halt)  state_d = ST_HALT;
               else            state_d = ST_FETCH;
            end
         end
         default:  state_d = state_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= RESET_PC;
         inst_q       <= NOP_INST;
         instret_q    <= 32'd0;
         trap_cause_q <= TRAP_NONE;
         trap_pc_q    <= 32'd0;
         tmo_cnt      <= '0;
      end else begin
         unique case (state_q)
            ST_FETCH: begin
               if (imem_ack) begin
                  inst_q  <= imem_rdata;
                  tmo_cnt <= '0;
               end else begin
                  tmo_cnt <= tmo_cnt + CW'(1);
                  if (timeout_hit) begin
                     trap_cause_q <= TRAP_TIMEOUT;
                     trap_pc_q    <= pc_q;
                  end
               end
            end
            ST_EXEC: begin
               // A misaligned target traps without retiring or moving the PC.
               if (!exec_stall) begin
                  if (misaligned) begin
                     trap_cause_q <= TRAP_MISALIGN;
                     trap_pc_q    <= npc;
                  end else begin
                     pc_q      <= npc;
                     instret_q <= instret_q + 32'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign imem_req      = (state_q == ST_FETCH);
   assign imem_addr     = pc_q;
   assign inst          = inst_q;
   assign inst_valid    = (state_q == ST_EXEC);
   assign npc_op        = (state_q == ST_EXEC) ? dec_npc_op : NPC_SEQ;
   assign npc_if_branch = dec_br_taken & (state_q == ST_EXEC);
   assign pc            = pc_q;
   assign halted        = (state_q == ST_HALT) || (state_q == ST_TRAP);
   assign trap          = (state_q == ST_TRAP);
   assign trap_cause    = trap_cause_q;
   assign trap_pc       = trap_pc_q;
   assign instret       = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: acts as imem and NPC unit, predicting fetch addresses,
// latched instructions, retire count and trap/halt outcomes per instruction.
module tb_pc_sequencer;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_ack = 1'b0;
   logic        ack2 = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic [1:0]  dec_npc_op = 2'b00;
   logic        dec_br_taken = 1'b0;
   logic [31:0] npc = 32'd0;
   logic        exec_stall = 1'b0;
   logic        halt = 1'b0;

   logic        imem_req, inst_valid, npc_if_branch, halted, trap;
   logic [31:0] imem_addr, inst, pc, trap_pc, instret;
   logic [1:0]  npc_op, trap_cause;

   logic        t_req, t_iv, t_br, t_halted, t_trap;
   logic [31:0] t_addr, t_inst, t_pc, t_trap_pc, t_instret;
   logic [1:0]  t_op, t_cause;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_pc, m_inst, m_instret;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(32'h0), .FETCH_TIMEOUT(255)) dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid), .dec_npc_op(dec_npc_op),
      .dec_br_taken(dec_br_taken), .npc_op(npc_op), .npc_if_branch(npc_if_branch), .pc(pc),
      .npc(npc), .exec_stall(exec_stall), .halt(halt), .halted(halted), .trap(trap),
      .trap_cause(trap_cause), .trap_pc(trap_pc), .instret(instret));

   pc_sequencer #(.RESET_PC(32'h0), .FETCH_TIMEOUT(4)) dut_tmo (
      .clk(clk), .rst(rst), .imem_req(t_req), .imem_addr(t_addr), .imem_ack(ack2),
      .imem_rdata(imem_rdata), .inst(t_inst), .inst_valid(t_iv), .dec_npc_op(dec_npc_op),
      .dec_br_taken(dec_br_taken), .npc_op(t_op), .npc_if_branch(t_br), .pc(t_pc),
      .npc(npc), .exec_stall(exec_stall), .halt(halt), .halted(t_halted), .trap(t_trap),
      .trap_cause(t_cause), .trap_pc(t_trap_pc), .instret(t_instret));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the DUT in IDLE (first cycle after rst falls) with the model reset.
   task automatic do_reset(input int n);
      rst = 1'b1;
      repeat (n) tick();
      rst = 1'b0;
      m_pc = 32'h0;
      m_inst = NOP_INST;
      m_instret = 32'd0;
   endtask

   // Runs one instruction starting in a FETCH cycle: ack after dly wait cycles,
   // stall EXEC for 'stall' cycles, then commit with target nxt.
   task automatic do_instr(input int dly, input logic [1:0] op, input logic br,
                           input logic [31:0] nxt, input int stall, input logic hlt);
      logic [31:0] word;
      word = $urandom;
      for (int i = 0; i <= dly; i++) begin
         dec_npc_op = op; dec_br_taken = br; npc = $urandom;
         #1;
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== m_pc) begin
            failures++;
            $display("FAIL fetch_req req=%0b addr=%h expected req=1 addr=%h", imem_req, imem_addr, m_pc);
         end
         checks++;
         if (inst_valid !== 1'b0 || npc_op !== NPC_SEQ || npc_if_branch !== 1'b0 || inst !== m_inst) begin
            failures++;
            $display("FAIL fetch_gating iv=%0b op=%0b br=%0b inst=%h expected 0/00/0 inst=%h",
                     inst_valid, npc_op, npc_if_branch, inst, m_inst);
         end
         imem_ack = (i == dly);
         imem_rdata = (i == dly) ? word : $urandom;
         tick();
      end
      imem_ack = 1'b0;
      imem_rdata = $urandom;
      m_inst = word;
      for (int s = 0; s <= stall; s++) begin
         exec_stall = (s < stall);
         halt = (s < stall) ? 1'($urandom) : hlt;
         npc = (s < stall) ? $urandom : nxt;
         #1;
         checks++;
         if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst !== m_inst || pc !== m_pc || instret !== m_instret) begin
            failures++;
            $display("FAIL exec_state iv=%0b req=%0b inst=%h pc=%h ret=%0d expected 1/0 inst=%h pc=%h ret=%0d",
                     inst_valid, imem_req, inst, pc, instret, m_inst, m_pc, m_instret);
         end
         checks++;
         if (npc_op !== op || npc_if_branch !== br) begin
            failures++;
            $display("FAIL exec_pass op=%0b br=%0b expected op=%0b br=%0b", npc_op, npc_if_branch, op, br);
         end
         tick();
      end
      exec_stall = 1'b0;
      halt = 1'b0;
      if (nxt[1:0] != 2'b00) begin
         checks++;
         if (trap !== 1'b1 || halted !== 1'b1 || trap_cause !== TRAP_MISALIGN || trap_pc !== nxt ||
             pc !== m_pc || instret !== m_instret || imem_req !== 1'b0) begin
            failures++;
            $display("FAIL misalign_trap trap=%0b halted=%0b cause=%0b tpc=%h pc=%h ret=%0d req=%0b expected 1/1/01 tpc=%h pc=%h ret=%0d req=0",
                     trap, halted, trap_cause, trap_pc, pc, instret, imem_req, nxt, m_pc, m_instret);
         end
      end else begin
         m_pc = nxt;
         m_instret = m_instret + 32'd1;
         checks++;
         if (pc !== m_pc || instret !== m_instret || halted !== hlt || trap !== 1'b0 || imem_req !== !hlt) begin
            failures++;
            $display("FAIL commit pc=%h ret=%0d halted=%0b trap=%0b req=%0b expected pc=%h ret=%0d halted=%0b trap=0 req=%0b",
                     pc, instret, halted, trap, imem_req, m_pc, m_instret, hlt, !hlt);
         end
      end
   endtask

   task automatic test_reset();
      do_reset(3);
      // rst has just dropped; the reset values are still what the DUT shows
      checks++;
      if (imem_req !== 1'b0 || pc !== 32'h0 || inst !== NOP_INST || inst_valid !== 1'b0 || halted !== 1'b0 ||
          trap !== 1'b0 || trap_cause !== TRAP_NONE || trap_pc !== 32'h0 || instret !== 32'd0 || npc_op !== 2'b00) begin
         failures++;
         $display("FAIL reset_values req=%0b pc=%h inst=%h iv=%0b halted=%0b trap=%0b cause=%0b tpc=%h ret=%0d op=%0b",
                  imem_req, pc, inst, inst_valid, halted, trap, trap_cause, trap_pc, instret, npc_op);
      end
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL first_fetch req=%0b addr=%h expected req=1 addr=0", imem_req, imem_addr);
      end
   endtask

   task automatic test_sequential();
      for (int k = 0; k < 3; k++) do_instr(0, NPC_SEQ, 1'b0, m_pc + 32'd4, 0, 1'b0);
      checks++;
      if (instret !== 32'd3 || pc !== 32'hC) begin
         failures++;
         $display("FAIL seq_retire ret=%0d pc=%h expected ret=3 pc=c", instret, pc);
      end
   endtask

   task automatic test_branch();
      do_instr(0, NPC_SEQ, 1'b0, 32'h10, 0, 1'b0);
      do_instr(0, NPC_BR, 1'b1, 32'h40, 0, 1'b0);
      do_instr(0, NPC_BR, 1'b0, 32'h44, 0, 1'b0);
      checks++;
      if (imem_addr !== 32'h44) begin
         failures++;
         $display("FAIL branch_target addr=%h expected 44", imem_addr);
      end
   endtask

   task automatic test_wait_stall();
      do_instr(3, NPC_JAL, 1'b0, 32'h100, 2, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] r;
      for (int k = 0; k < 30; k++) begin
         r = $urandom;
         if (r[0]) r = m_pc + 32'd4;
         r = r & 32'hFFFF_FFFC;
         do_instr($urandom_range(0, 5), 2'($urandom), 1'($urandom), r, $urandom_range(0, 3), 1'b0);
      end
   endtask

   task automatic test_halt();
      do_instr(1, NPC_JAL, 1'b0, m_pc + 32'd8, 1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         imem_ack = 1'b1; imem_rdata = $urandom; dec_npc_op = NPC_JAL; dec_br_taken = 1'b1;
         #1;
         checks++;
         if (imem_req !== 1'b0 || halted !== 1'b1 || inst_valid !== 1'b0 || npc_op !== 2'b00 ||
             npc_if_branch !== 1'b0 || inst !== m_inst || pc !== m_pc) begin
            failures++;
            $display("FAIL halt_hold req=%0b halted=%0b iv=%0b op=%0b br=%0b inst=%h pc=%h expected 0/1/0/00/0 inst=%h pc=%h",
                     imem_req, halted, inst_valid, npc_op, npc_if_branch, inst, pc, m_inst, m_pc);
         end
         tick();
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_reset_mid_fetch();
      do_reset(1);
      tick();
      do_instr(0, NPC_SEQ, 1'b0, 32'h4, 0, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      m_pc = 32'h0; m_inst = NOP_INST; m_instret = 32'd0;
      checks++;
      if (imem_req !== 1'b0 || pc !== 32'h0 || instret !== 32'd0) begin
         failures++;
         $display("FAIL mid_fetch_reset req=%0b pc=%h ret=%0d expected req=0 pc=0 ret=0", imem_req, pc, instret);
      end
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      checks++;
      if (inst !== NOP_INST || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         failures++;
         $display("FAIL late_ack inst=%h req=%0b addr=%h expected inst=13 req=1 addr=0", inst, imem_req, imem_addr);
      end
      do_instr(0, NPC_SEQ, 1'b0, 32'h4, 0, 1'b0);
   endtask

   task automatic test_misaligned();
      do_instr(0, NPC_JALR, 1'b0, 32'h102, 1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         imem_ack = 1'b1; npc = 32'h200;
         tick();
         checks++;
         if (imem_req !== 1'b0 || trap !== 1'b1 || trap_cause !== TRAP_MISALIGN || trap_pc !== 32'h102 || pc !== m_pc) begin
            failures++;
            $display("FAIL trap_hold req=%0b trap=%0b cause=%0b tpc=%h pc=%h expected 0/1/01 tpc=102 pc=%h",
                     imem_req, trap, trap_cause, trap_pc, pc, m_pc);
         end
      end
      imem_ack = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset(2);
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if (t_req !== 1'b1 || t_addr !== 32'h0 || t_trap !== 1'b0) begin
            failures++;
            $display("FAIL timeout_wait cyc=%0d req=%0b addr=%h trap=%0b expected req=1 addr=0 trap=0", k, t_req, t_addr, t_trap);
         end
      end
      tick();
      checks++;
      if (t_trap !== 1'b1 || t_halted !== 1'b1 || t_cause !== TRAP_TIMEOUT || t_trap_pc !== 32'h0 || t_req !== 1'b0) begin
         failures++;
         $display("FAIL timeout_trap trap=%0b halted=%0b cause=%0b tpc=%h req=%0b expected 1/1/10 tpc=0 req=0",
                  t_trap, t_halted, t_cause, t_trap_pc, t_req);
      end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_wait_stall();
      test_random();
      test_halt();
      test_reset_mid_fetch();
      test_misaligned();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
